// File: rtl/mmio_timer_bank_if.sv
// CPU data-bus view of the timer region: select, write strobe, byte address,
// write data and combinational read data.
interface mmio_timer_bank_if;
  logic        sel;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_timer_bank.sv
// Bank of NUM_CH memory-mapped timers sharing the system clock. Each channel has
// a prescaler, count, compare, sticky match flag and periodic/one-shot control.
module mmio_timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int PRE_W     = 24,
  parameter int RESET_DIV = 1,
  parameter int RESET_EN  = 1
) (
  input  logic                clock,
  input  logic                reset,
  mmio_timer_bank_if.slave    bus,
  output logic                irq
);

  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [PRE_W-1:0] pre_q   [NUM_CH];
  logic [PRE_W-1:0] div_q   [NUM_CH];
  logic [CNT_W-1:0] cmp_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q, periodic_q, oneshot_q, irq_en_q, match_q;

  logic [CNT_W-1:0] next_cnt [NUM_CH];
  logic [NUM_CH-1:0] tick, hit, wr_ch, wr_count;
  logic [3:0]  ch;
  logic [1:0]  reg_idx;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign ch               = bus.addr[7:4];
  assign reg_idx          = bus.addr[3:2];
  assign unused_addr_bits = ^bus.addr[1:0];

  // A divisor of 0 behaves like 1, so the terminal prescale value is then 0.
  always_comb begin
    tick     = '0;
    hit      = '0;
    wr_ch    = '0;
    wr_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      next_cnt[i] = count_q[i] + CNT_W'(1);
      tick[i]     = en_q[i] &&
                    (pre_q[i] == ((div_q[i] == '0) ? '0 : div_q[i] - PRE_W'(1)));
      wr_ch[i]    = bus.sel && bus.we && (ch == 4'(i));
      wr_count[i] = wr_ch[i] && (reg_idx == 2'd0);
      hit[i]      = tick[i] && !wr_count[i] && (next_cnt[i] == cmp_q[i]);
    end
  end

  // Bus writes come last so they override the tick/reload/one-shot updates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]    <= '0;
        pre_q[i]      <= '0;
        div_q[i]      <= PRE_W'(RESET_DIV);
        cmp_q[i]      <= '1;
        en_q[i]       <= (RESET_EN != 0);
        periodic_q[i] <= 1'b0;
        oneshot_q[i]  <= 1'b0;
        irq_en_q[i]   <= 1'b0;
        match_q[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick[i]) begin
          pre_q[i]   <= '0;
          count_q[i] <= (hit[i] && periodic_q[i]) ? '0 : next_cnt[i];
        end else if (en_q[i]) begin
          pre_q[i] <= pre_q[i] + PRE_W'(1);
        end
        if (hit[i]) begin
          match_q[i] <= 1'b1;
          if (oneshot_q[i]) en_q[i] <= 1'b0;
        end
        if (wr_ch[i]) begin
          case (reg_idx)
            2'd0: begin
              count_q[i] <= bus.wdata[CNT_W-1:0];
              pre_q[i]   <= '0;
            end
            2'd1: begin
              div_q[i] <= bus.wdata[PRE_W-1:0];
              pre_q[i] <= '0;
            end
            2'd2: cmp_q[i] <= bus.wdata[CNT_W-1:0];
            default: begin
              en_q[i]       <= bus.wdata[0];
              periodic_q[i] <= bus.wdata[1];
              oneshot_q[i]  <= bus.wdata[2];
              irq_en_q[i]   <= bus.wdata[3];
              if (bus.wdata[8] && !hit[i]) match_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.sel) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == 4'(i)) begin
          case (reg_idx)
            2'd0:    rd_data = 32'(count_q[i]);
            2'd1:    rd_data = 32'(div_q[i]);
            2'd2:    rd_data = 32'(cmp_q[i]);
            default: rd_data = {23'd0, match_q[i], 4'd0,
                                irq_en_q[i], oneshot_q[i], periodic_q[i], en_q[i]};
          endcase
        end
      end
    end
  end

  assign bus.rdata = rd_data;
  assign irq       = |(match_q & irq_en_q);

endmodule

// File: doc/mmio_timer_bank.md
Name: mmio_timer_bank

Overview:
Parametrised bank of NUM_CH memory-mapped time counters. It replaces the fixed second, millisecond and microsecond counters that each run on their own derived clock. Every channel runs in the single system clock domain and has:
- a programmable prescaler
- a writable count
- a compare register
- sticky match flag, periodic/one-shot modes and an interrupt enable

It sits behind the top-level MMIO decode on the CPU data bus and is selected by its MemType region. It drives a single OR-ed irq line.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CNT_W, 32, count and compare width (1..32); upper rdata bits read 0
PRE_W, 24, prescaler divisor width (1..32)
RESET_DIV, 1, divisor loaded at reset for every channel
RESET_EN, 1, enable bit state at reset (1 = free-running time base from power-up)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low; 0 at a posedge resets all state
sel  in  1  region select (MemType matches timer region)
we  in  1  write strobe, qualified by sel
addr  in  8  byte address inside region: ch = addr[7:4], reg = addr[3:2], addr[1:0] ignored
wdata  in  32  write data
rdata  out  32  combinational read data
irq  out  1  OR over channels of (MATCH & IRQ_EN)

Behaviour:
- Register map per channel (reg index):
  - 0 COUNT (RW)
  - 1 DIV (RW, PRE_W bits)
  - 2 CMP (RW, CNT_W bits)
  - 3 CTRL (RW). Bits: bit0 EN, bit1 PERIODIC, bit2 ONESHOT, bit3 IRQ_EN, bit8 MATCH (read = flag; write 1 = clear, write 0 = no effect). Other bits read 0.
- Reset, per channel: COUNT=0, prescaler pre=0, DIV=RESET_DIV, CMP=all ones, EN=RESET_EN, all other CTRL bits 0. Outputs: irq=0; rdata reflects reset state.
- Effective divisor: d = (DIV==0) ? 1 : DIV.
- Tick:
  - When EN=1 and pre==d-1, a tick occurs: pre←0, next = COUNT+1 (mod 2^CNT_W).
  - Otherwise, if EN=1: pre←pre+1. If EN=0: pre holds.
  - With d=1, a tick occurs every cycle.
- Match: on a tick where next==CMP:
  - MATCH←1.
  - If PERIODIC=1, COUNT←0; otherwise COUNT←next.
  - If ONESHOT=1, EN←0 in the same cycle.
  - PERIODIC and ONESHOT both set: reload to 0 and stop.
- Wrap: COUNT all-ones + tick → 0. This sets MATCH only if CMP==0.
- Writes: take effect at the posedge where sel & we & ch<NUM_CH. Writes to ch≥NUM_CH are ignored.
- Write COUNT: COUNT←wdata, pre←0. The write overrides any tick or reload in the same cycle, and no MATCH is evaluated that cycle.
- Write DIV: DIV←wdata, pre←0. A tick in that same cycle is still applied.
- Write CMP: takes effect for comparisons from the next cycle.
- Write CTRL: EN, PERIODIC, ONESHOT and IRQ_EN are updated. A ONESHOT stop in the same cycle is overridden by the written EN.
- MATCH conflict: a write-1-clear and a hardware set in the same cycle → MATCH=1 (set wins).
- Read:
  - rdata is a pure combinational function of addr and registered state.
  - Reads are valid when sel=1; rdata=0 when sel=0 or ch≥NUM_CH.
  - Reading has no side effects.
- irq: combinational OR of registered MATCH&IRQ_EN, therefore glitch-free. It asserts the cycle after the matching tick edge and stays high until cleared or IRQ_EN=0.
- Reset asserted mid-count or mid-prescale returns all channels to reset values at that posedge; partial prescale is discarded.

Test Plan:
1. Reset (reset=0 for 2 cycles, RESET_DIV=1, RESET_EN=1), then run 10 cycles → ch0 COUNT reads 10; DIV reads 1; CMP reads 0xFFFFFFFF; irq=0.
2. ch1 DIV=100, COUNT=0, EN=1 → COUNT=0 until cycle 100, then 1; after 1000 cycles COUNT=10. DIV=0 → increments every cycle.
3. ch2 CMP=5, PERIODIC=1, IRQ_EN=1, DIV=1:
   - COUNT sequence 1,2,3,4,0,1…
   - irq rises the cycle after COUNT reload.
   - Write CTRL with bit8=1 and bit3=1 → irq=0 next cycle.
   - Clear issued on a match cycle → MATCH stays 1.
4. ch3 ONESHOT=1, CMP=3, DIV=2 → COUNT stops at 3 with EN=0 after 6 cycles and stays 3; MATCH=1.
5. Wrap: COUNT=0xFFFFFFFE, CMP=0, DIV=1 → FFFFFFFF, then 0 with MATCH=1.
6. Conflicts:
   - Write COUNT=7 on a tick cycle → reads 7, no MATCH even if CMP=next.
   - Write to ch=NUM_CH → no state change, read returns 0.
   - reset=0 mid-prescale → all reset values next cycle.
